// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/func
// fields, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_WB      = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        CLS_R       = 2'd0,
        CLS_I       = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_LUI = 4'b1111;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Instruction-register / datapath-control bundle between the multicycle datapath
// (master) and the control sequencer (slave).
interface mips_multicycle_control_if #(
    parameter int ALU_W = 4
);
    logic [5:0]       op_in;
    logic [5:0]       func_in;
    logic             zero_in;
    logic             mem_ready_in;
    logic             pcWrite_out;
    logic             irWrite_out;
    logic             iorD_out;
    logic             memRead_out;
    logic             memWrite_out;
    logic             memToReg_out;
    logic             regDst_out;
    logic             regWrite_out;
    logic             ALUSrcA_out;
    logic [1:0]       ALUSrcB_out;
    logic             extCntrl_out;
    logic [ALU_W-1:0] ALUCntrl_out;
    logic [1:0]       PCSource_out;
    logic             illegal_out;
    logic [3:0]       state_out;

    modport master (
        output op_in, func_in, zero_in, mem_ready_in,
        input  pcWrite_out, irWrite_out, iorD_out, memRead_out, memWrite_out,
               memToReg_out, regDst_out, regWrite_out, ALUSrcA_out, ALUSrcB_out,
               extCntrl_out, ALUCntrl_out, PCSource_out, illegal_out, state_out
    );

    modport slave (
        input  op_in, func_in, zero_in, mem_ready_in,
        output pcWrite_out, irWrite_out, iorD_out, memRead_out, memWrite_out,
               memToReg_out, regDst_out, regWrite_out, ALUSrcA_out, ALUSrcB_out,
               extCntrl_out, ALUCntrl_out, PCSource_out, illegal_out, state_out
    );
endinterface

// File: rtl/mips_multicycle_control_alu_decode.sv
// Combinational op/func decoder: ALU operation plus R-type / I-type / illegal class.
// Shared by the DECODE legality check and the EXEC ALU select.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output logic [3:0] o_alu,
    output op_class_t  o_cls
);

    // Map opcode/func to ALU operation and instruction class
    always_comb begin
        o_alu = ALU_AND;
        o_cls = CLS_ILLEGAL;
        case (i_op)
            OP_R: begin
                case (i_func)
                    FN_ADD:  begin o_alu = ALU_ADD; o_cls = CLS_R; end
                    FN_SUB:  begin o_alu = ALU_SUB; o_cls = CLS_R; end
                    FN_NOR:  begin o_alu = ALU_NOR; o_cls = CLS_R; end
                    FN_SLT:  begin o_alu = ALU_SLT; o_cls = CLS_R; end
                    default: begin o_alu = ALU_AND; o_cls = CLS_ILLEGAL; end
                endcase
            end
            OP_ADDI: begin o_alu = ALU_ADD; o_cls = CLS_I; end
            OP_ANDI: begin o_alu = ALU_AND; o_cls = CLS_I; end
            OP_LUI:  begin o_alu = ALU_LUI; o_cls = CLS_I; end
            default: begin o_alu = ALU_AND; o_cls = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore sequencer driving the shared-memory datapath,
// with optional memory wait handshake and illegal-instruction trap.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_W           = 4,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_multicycle_control_if.slave bus
);

    state_t     r_state;
    logic [5:0] r_op;
    logic [5:0] r_func;

    logic       w_ready;
    logic [5:0] w_dec_op;
    logic [5:0] w_dec_func;
    logic [3:0] w_dec_alu;
    op_class_t  w_dec_cls;

    logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write;
    logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_src_a, w_ext, w_illegal;
    logic [1:0] w_src_b, w_pc_source;
    logic [3:0] w_alu;

    assign w_ready = bus.mem_ready_in | (MEM_HANDSHAKE == 1'b0);

    // In DECODE the instruction register is live; afterwards the latched copy is used.
    assign w_dec_op   = (r_state == S_DECODE) ? bus.op_in   : r_op;
    assign w_dec_func = (r_state == S_DECODE) ? bus.func_in : r_func;

    mips_alu_decode u_alu_decode (
        .i_op   (w_dec_op),
        .i_func (w_dec_func),
        .o_alu  (w_dec_alu),
        .o_cls  (w_dec_cls)
    );

    // State register, next-state sequencing and op/func latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= 6'd0;
            r_func  <= 6'd0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= w_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    r_op   <= bus.op_in;
                    r_func <= bus.func_in;
                    case (bus.op_in)
                        OP_LW, OP_SW:   r_state <= S_MEMADR;
                        OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                        OP_J:           r_state <= S_JUMP;
                        default: begin
                            if ((bus.op_in == OP_R) && (bus.func_in == FN_NOP)) begin
                                r_state <= S_FETCH;
                            end else if (w_dec_cls != CLS_ILLEGAL) begin
                                r_state <= S_EXEC;
                            end else begin
                                r_state <= TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
                            end
                        end
                    endcase
                end
                S_MEMADR: begin
                    if (r_op == OP_LW) begin
                        r_state <= S_MEMRD;
                    end else if (r_op == OP_SW) begin
                        r_state <= S_MEMWR;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEMRD:   r_state <= w_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   r_state <= S_FETCH;
                S_MEMWR:   r_state <= w_ready ? S_FETCH : S_MEMWR;
                S_EXEC:    r_state <= S_WB;
                S_WB:      r_state <= S_FETCH;
                S_BRANCH:  r_state <= S_FETCH;
                S_JUMP:    r_state <= S_FETCH;
                S_ILLEGAL: r_state <= S_ILLEGAL;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_src_a      = 1'b0;
        w_src_b      = SRCB_REG;
        w_ext        = 1'b0;
        w_alu        = ALU_AND;
        w_pc_source  = PCSRC_ALU;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_src_b    = SRCB_FOUR;
                w_alu      = ALU_ADD;
                w_ir_write = w_ready;
                w_pc_write = w_ready;
            end
            S_DECODE: begin
                w_src_b = SRCB_IMM_SH2;
                w_alu   = ALU_ADD;
                w_ext   = 1'b1;
            end
            S_MEMADR: begin
                w_src_a = 1'b1;
                w_src_b = SRCB_IMM;
                w_ext   = 1'b1;
                w_alu   = ALU_ADD;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_EXEC: begin
                w_src_a = 1'b1;
                w_alu   = w_dec_alu;
                if (r_op == OP_R) begin
                    w_src_b = SRCB_REG;
                end else begin
                    w_src_b = SRCB_IMM;
                    w_ext   = (r_op == OP_ADDI);
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = (r_op == OP_R);
            end
            S_BRANCH: begin
                w_src_a     = 1'b1;
                w_src_b     = SRCB_REG;
                w_alu       = ALU_SUB;
                w_pc_source = PCSRC_ALUOUT;
                w_pc_write  = ((r_op == OP_BEQ) & bus.zero_in) |
                              ((r_op == OP_BNE) & ~bus.zero_in);
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = PCSRC_JUMP;
            end
            S_ILLEGAL: w_illegal = 1'b1;
            default:   w_illegal = 1'b0;
        endcase
    end

    // Reset suppresses every write strobe and the trap flag regardless of state.
    assign bus.pcWrite_out  = w_pc_write  & ~reset;
    assign bus.irWrite_out  = w_ir_write  & ~reset;
    assign bus.memRead_out  = w_mem_read  & ~reset;
    assign bus.memWrite_out = w_mem_write & ~reset;
    assign bus.regWrite_out = w_reg_write & ~reset;
    assign bus.illegal_out  = w_illegal   & ~reset;
    assign bus.iorD_out     = w_iord;
    assign bus.memToReg_out = w_mem_to_reg;
    assign bus.regDst_out   = w_reg_dst;
    assign bus.ALUSrcA_out  = w_src_a;
    assign bus.ALUSrcB_out  = w_src_b;
    assign bus.extCntrl_out = w_ext;
    assign bus.ALUCntrl_out = ALU_W'(w_alu);
    assign bus.PCSource_out = w_pc_source;
    assign bus.state_out    = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: one instance with handshake/trap,
// one with both disabled; per-cycle expected outputs are queued and checked on negedge.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, iord, mr, mw, m2r, rd, rw, srca;
        logic [1:0] srcb;
        logic       ext;
        logic [3:0] alu;
        logic [1:0] pcs;
        logic       ill;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_control_if #(.ALU_W(4)) bus_a ();
    mips_multicycle_control_if #(.ALU_W(4)) bus_b ();

    mips_multicycle_control #(.ALU_W(4), .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) u_dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
    );
    mips_multicycle_control #(.ALU_W(4), .MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) u_dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
    );

    obs_t  q_a[$];
    obs_t  q_b[$];
    string n_a[$];
    string n_b[$];
    int    checks = 0;
    int    errors = 0;

    // Expected outputs for a state; pcw/irw feed FETCH and BRANCH, alu/srcb/ext feed EXEC, rd feeds WB
    function automatic obs_t e(input logic [3:0] st, input logic rst, input logic pcw, input logic irw,
                               input logic [3:0] alu, input logic [1:0] srcb, input logic ext, input logic rd);
        obs_t o;
        o = '0;
        o.st = st;
        case (st)
            4'd0:  begin o.mr = 1'b1; o.srcb = 2'd1; o.alu = 4'b0010; o.pcw = pcw; o.irw = irw; end
            4'd1:  begin o.srcb = 2'd3; o.alu = 4'b0010; o.ext = 1'b1; end
            4'd2:  begin o.srca = 1'b1; o.srcb = 2'd2; o.ext = 1'b1; o.alu = 4'b0010; end
            4'd3:  begin o.mr = 1'b1; o.iord = 1'b1; end
            4'd4:  begin o.rw = 1'b1; o.m2r = 1'b1; end
            4'd5:  begin o.mw = 1'b1; o.iord = 1'b1; end
            4'd6:  begin o.srca = 1'b1; o.alu = alu; o.srcb = srcb; o.ext = ext; end
            4'd7:  begin o.rw = 1'b1; o.rd = rd; end
            4'd8:  begin o.srca = 1'b1; o.alu = 4'b0110; o.pcs = 2'd1; o.pcw = pcw; end
            4'd9:  begin o.pcw = 1'b1; o.pcs = 2'd2; end
            4'd10: o.ill = 1'b1;
            default: o.ill = 1'b0;
        endcase
        if (rst) begin
            o.pcw = 1'b0; o.irw = 1'b0; o.mr = 1'b0; o.mw = 1'b0; o.rw = 1'b0; o.ill = 1'b0;
        end
        return o;
    endfunction

    task automatic step(input bit alt, input string nm, input logic rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic rdy, input obs_t ex);
        @(posedge clk);
        #1;
        if (alt) begin
            rst_b = rst; bus_b.op_in = op; bus_b.func_in = fn; bus_b.zero_in = z; bus_b.mem_ready_in = rdy;
            q_b.push_back(ex); n_b.push_back(nm);
        end else begin
            rst_a = rst; bus_a.op_in = op; bus_a.func_in = fn; bus_a.zero_in = z; bus_a.mem_ready_in = rdy;
            q_a.push_back(ex); n_a.push_back(nm);
        end
    endtask

    task automatic alu_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic [3:0] alu, input logic [1:0] srcb, input logic ext, input logic rd);
        step(1'b0, {nm, "_fetch"},  1'b0, op, fn, 1'b0, 1'b1, e(4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0));
        step(1'b0, {nm, "_decode"}, 1'b0, op, fn, 1'b0, 1'b1, e(4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0));
        step(1'b0, {nm, "_exec"},   1'b0, op, fn, 1'b0, 1'b1, e(4'd6, 1'b0, 1'b0, 1'b0, alu, srcb, ext, 1'b0));
        step(1'b0, {nm, "_wb"},     1'b0, op, fn, 1'b0, 1'b1, e(4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, rd));
    endtask

    task automatic branch(input string nm, input logic [5:0] op, input logic z, input logic pcw);
        step(1'b0, {nm, "_fetch"},  1'b0, op, 6'h00, z, 1'b1, e(4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0));
        step(1'b0, {nm, "_decode"}, 1'b0, op, 6'h00, z, 1'b1, e(4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0));
        step(1'b0, {nm, "_branch"}, 1'b0, op, 6'h00, z, 1'b1, e(4'd8, 1'b0, pcw, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0));
    endtask

    // Short form for non-EXEC/WB/BRANCH states on either instance
    task automatic s(input bit alt, input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [3:0] st, input logic pcw, input logic irw);
        step(alt, nm, rst, op, fn, 1'b0, rdy, e(st, rst, pcw, irw, 4'd0, 2'd0, 1'b0, 1'b0));
    endtask

    function automatic void chk(input string nm, input obs_t act, input obs_t ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endfunction

    // Monitor: every cycle with a queued expectation is compared on the falling edge
    always @(negedge clk) begin : monitor
        obs_t act;
        if (q_a.size() > 0) begin
            act = {bus_a.state_out, bus_a.pcWrite_out, bus_a.irWrite_out, bus_a.iorD_out, bus_a.memRead_out,
                   bus_a.memWrite_out, bus_a.memToReg_out, bus_a.regDst_out, bus_a.regWrite_out,
                   bus_a.ALUSrcA_out, bus_a.ALUSrcB_out, bus_a.extCntrl_out, bus_a.ALUCntrl_out,
                   bus_a.PCSource_out, bus_a.illegal_out};
            chk(n_a.pop_front(), act, q_a.pop_front());
        end
        if (q_b.size() > 0) begin
            act = {bus_b.state_out, bus_b.pcWrite_out, bus_b.irWrite_out, bus_b.iorD_out, bus_b.memRead_out,
                   bus_b.memWrite_out, bus_b.memToReg_out, bus_b.regDst_out, bus_b.regWrite_out,
                   bus_b.ALUSrcA_out, bus_b.ALUSrcB_out, bus_b.extCntrl_out, bus_b.ALUCntrl_out,
                   bus_b.PCSource_out, bus_b.illegal_out};
            chk({"alt_", n_b.pop_front()}, act, q_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus_a.op_in = 6'h00; bus_a.func_in = 6'h00; bus_a.zero_in = 1'b0; bus_a.mem_ready_in = 1'b1;
        bus_b.op_in = 6'h00; bus_b.func_in = 6'h00; bus_b.zero_in = 1'b0; bus_b.mem_ready_in = 1'b0;
        fork
            begin : seq_a
                s(1'b0, "rst0", 1'b1, 6'h00, 6'h00, 1'b1, 4'd0, 1'b0, 1'b0);
                s(1'b0, "rst1", 1'b1, 6'h00, 6'h00, 1'b1, 4'd0, 1'b0, 1'b0);
                alu_instr("add",  6'h00, 6'h20, 4'b0010, 2'd0, 1'b0, 1'b1);
                alu_instr("sub",  6'h00, 6'h22, 4'b0110, 2'd0, 1'b0, 1'b1);
                alu_instr("nor",  6'h00, 6'h27, 4'b1100, 2'd0, 1'b0, 1'b1);
                alu_instr("slt",  6'h00, 6'h2a, 4'b0111, 2'd0, 1'b0, 1'b1);
                alu_instr("addi", 6'h08, 6'h00, 4'b0010, 2'd2, 1'b1, 1'b0);
                alu_instr("andi", 6'h0c, 6'h00, 4'b0000, 2'd2, 1'b0, 1'b0);
                alu_instr("lui",  6'h0f, 6'h00, 4'b1111, 2'd2, 1'b0, 1'b0);
                // lw with two wait cycles in MEMRD
                s(1'b0, "lw_fetch",  1'b0, 6'h23, 6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
                s(1'b0, "lw_decode", 1'b0, 6'h23, 6'h00, 1'b1, 4'd1, 1'b0, 1'b0);
                s(1'b0, "lw_memadr", 1'b0, 6'h23, 6'h00, 1'b1, 4'd2, 1'b0, 1'b0);
                s(1'b0, "lw_memrd0", 1'b0, 6'h23, 6'h00, 1'b0, 4'd3, 1'b0, 1'b0);
                s(1'b0, "lw_memrd1", 1'b0, 6'h23, 6'h00, 1'b0, 4'd3, 1'b0, 1'b0);
                s(1'b0, "lw_memrd2", 1'b0, 6'h23, 6'h00, 1'b1, 4'd3, 1'b0, 1'b0);
                s(1'b0, "lw_memwb",  1'b0, 6'h23, 6'h00, 1'b1, 4'd4, 1'b0, 1'b0);
                // sw with a FETCH wait and a MEMWR wait
                s(1'b0, "sw_fetchw", 1'b0, 6'h2b, 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
                s(1'b0, "sw_fetch",  1'b0, 6'h2b, 6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
                s(1'b0, "sw_decode", 1'b0, 6'h2b, 6'h00, 1'b1, 4'd1, 1'b0, 1'b0);
                s(1'b0, "sw_memadr", 1'b0, 6'h2b, 6'h00, 1'b1, 4'd2, 1'b0, 1'b0);
                s(1'b0, "sw_memwr0", 1'b0, 6'h2b, 6'h00, 1'b0, 4'd5, 1'b0, 1'b0);
                s(1'b0, "sw_memwr1", 1'b0, 6'h2b, 6'h00, 1'b1, 4'd5, 1'b0, 1'b0);
                branch("beq_z1", 6'h04, 1'b1, 1'b1);
                branch("bne_z1", 6'h05, 1'b1, 1'b0);
                branch("beq_z0", 6'h04, 1'b0, 1'b0);
                branch("bne_z0", 6'h05, 1'b0, 1'b1);
                s(1'b0, "j_fetch",   1'b0, 6'h02, 6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
                s(1'b0, "j_decode",  1'b0, 6'h02, 6'h00, 1'b1, 4'd1, 1'b0, 1'b0);
                s(1'b0, "j_jump",    1'b0, 6'h02, 6'h00, 1'b1, 4'd9, 1'b1, 1'b0);
                s(1'b0, "nop_fetch", 1'b0, 6'h00, 6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
                s(1'b0, "nop_decode",1'b0, 6'h00, 6'h00, 1'b1, 4'd1, 1'b0, 1'b0);
                // sw interrupted by reset while waiting in MEMWR
                s(1'b0, "swr_fetch", 1'b0, 6'h2b, 6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
                s(1'b0, "swr_decode",1'b0, 6'h2b, 6'h00, 1'b1, 4'd1, 1'b0, 1'b0);
                s(1'b0, "swr_memadr",1'b0, 6'h2b, 6'h00, 1'b1, 4'd2, 1'b0, 1'b0);
                s(1'b0, "swr_memwr", 1'b0, 6'h2b, 6'h00, 1'b0, 4'd5, 1'b0, 1'b0);
                s(1'b0, "swr_rsthi", 1'b1, 6'h2b, 6'h00, 1'b0, 4'd5, 1'b0, 1'b0);
                s(1'b0, "swr_rstst", 1'b1, 6'h2b, 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
                // illegal opcode traps until reset
                s(1'b0, "ill_fetch", 1'b0, 6'h3f, 6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
                s(1'b0, "ill_decode",1'b0, 6'h3f, 6'h00, 1'b1, 4'd1, 1'b0, 1'b0);
                for (int i = 0; i < 11; i++) begin
                    s(1'b0, $sformatf("ill_hold%0d", i), 1'b0, 6'h3f, 6'h00, 1'b1, 4'd10, 1'b0, 1'b0);
                end
                s(1'b0, "ill_rsthi", 1'b1, 6'h3f, 6'h00, 1'b1, 4'd10, 1'b0, 1'b0);
                s(1'b0, "ill_rstst", 1'b1, 6'h3f, 6'h00, 1'b1, 4'd0, 1'b0, 1'b0);
                // R-type with an unknown func also traps
                s(1'b0, "badfn_fetch",  1'b0, 6'h00, 6'h21, 1'b1, 4'd0, 1'b1, 1'b1);
                s(1'b0, "badfn_decode", 1'b0, 6'h00, 6'h21, 1'b1, 4'd1, 1'b0, 1'b0);
                s(1'b0, "badfn_ill",    1'b0, 6'h00, 6'h21, 1'b1, 4'd10, 1'b0, 1'b0);
                s(1'b0, "badfn_rsthi",  1'b1, 6'h00, 6'h21, 1'b1, 4'd10, 1'b0, 1'b0);
                s(1'b0, "badfn_rstst",  1'b1, 6'h00, 6'h21, 1'b1, 4'd0, 1'b0, 1'b0);
                alu_instr("add2", 6'h00, 6'h20, 4'b0010, 2'd0, 1'b0, 1'b1);
            end
            begin : seq_b
                s(1'b1, "rst0", 1'b1, 6'h00, 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
                s(1'b1, "rst1", 1'b1, 6'h00, 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
                // mem_ready_in held low: no wait states without the handshake
                s(1'b1, "lw_fetch",  1'b0, 6'h23, 6'h00, 1'b0, 4'd0, 1'b1, 1'b1);
                s(1'b1, "lw_decode", 1'b0, 6'h23, 6'h00, 1'b0, 4'd1, 1'b0, 1'b0);
                s(1'b1, "lw_memadr", 1'b0, 6'h23, 6'h00, 1'b0, 4'd2, 1'b0, 1'b0);
                s(1'b1, "lw_memrd",  1'b0, 6'h23, 6'h00, 1'b0, 4'd3, 1'b0, 1'b0);
                s(1'b1, "lw_memwb",  1'b0, 6'h23, 6'h00, 1'b0, 4'd4, 1'b0, 1'b0);
                s(1'b1, "ill_fetch", 1'b0, 6'h3f, 6'h00, 1'b0, 4'd0, 1'b1, 1'b1);
                s(1'b1, "ill_decode",1'b0, 6'h3f, 6'h00, 1'b0, 4'd1, 1'b0, 1'b0);
                s(1'b1, "ill_refetch",1'b0, 6'h3f, 6'h00, 1'b0, 4'd0, 1'b1, 1'b1);
            end
        join
        for (int i = 0; i < 5; i++) begin
            if ((q_a.size() > 0) || (q_b.size() > 0)) begin
                @(negedge clk);
                #1;
            end
        end
        checks++;
        if ((q_a.size() > 0) || (q_b.size() > 0)) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
